// File: rtl/tpu_host_sequencer.sv
// Host-side sequencer for the TPU matrix controller: loads 8 operand bytes
// (A0..A3, B0..B3), waits for done, then drains the 4 result bytes.
// Optional WAIT watchdog enabled by defining TPU_SEQ_TIMEOUT_EN.
module tpu_host_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       load_en,
    output logic       load_sel_ab,
    output logic [1:0] load_index,
    output logic [7:0] load_data,
    input  logic       done,
    output logic       output_en,
    output logic [1:0] output_sel,
    input  logic [7:0] out_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_byte,
    output logic       busy,
    output logic       err
);

`ifdef TPU_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_WAIT = 3'd1,
        ST_SEL  = 3'd2,
        ST_PRES = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
`else
    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_WAIT = 3'd1,
        ST_SEL  = 3'd2,
        ST_PRES = 3'd3
    } state_e;

    // Watchdog limit has no meaning when the watchdog is compiled out
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] ridx_q, ridx_d;
    logic       load_en_q, load_en_d;
    logic       load_sel_ab_q, load_sel_ab_d;
    logic [1:0] load_index_q, load_index_d;
    logic [7:0] load_data_q, load_data_d;
    logic [7:0] res_byte_q, res_byte_d;

    // Handshake and status outputs decode directly from state
    assign in_ready    = (state_q == ST_LOAD);
    assign output_en   = (state_q == ST_SEL);
    assign res_valid   = (state_q == ST_PRES);
    assign output_sel  = ((state_q == ST_SEL) || (state_q == ST_PRES)) ? ridx_q : 2'd0;
    assign busy        = !((state_q == ST_LOAD) && (cnt_q == 3'd0));
`ifdef TPU_SEQ_TIMEOUT_EN
    assign err         = (state_q == ST_ERR);
`else
    assign err         = 1'b0;
`endif

    assign load_en     = load_en_q;
    assign load_sel_ab = load_sel_ab_q;
    assign load_index  = load_index_q;
    assign load_data   = load_data_q;
    assign res_byte    = res_byte_q;

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ridx_d        = ridx_q;
        load_en_d     = 1'b0;
        load_sel_ab_d = load_sel_ab_q;
        load_index_d  = load_index_q;
        load_data_d   = load_data_q;
        res_byte_d    = res_byte_q;
`ifdef TPU_SEQ_TIMEOUT_EN
        wcnt_d        = '0;
`endif
        unique case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    load_en_d     = 1'b1;
                    load_sel_ab_d = cnt_q[2];
                    load_index_d  = cnt_q[1:0];
                    load_data_d   = in_byte;
                    cnt_d         = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (done) begin
                    state_d = ST_SEL;
                    ridx_d  = 2'd0;
`ifdef TPU_SEQ_TIMEOUT_EN
                end else if (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
`endif
                end
            end
            ST_SEL: begin
                res_byte_d = out_data;
                state_d    = ST_PRES;
            end
            ST_PRES: begin
                if (res_ready) begin
                    if (ridx_q == 2'd3) begin
                        state_d = ST_LOAD;
                    end else begin
                        ridx_d  = ridx_q + 2'd1;
                        state_d = ST_SEL;
                    end
                end
            end
`ifdef TPU_SEQ_TIMEOUT_EN
            ST_ERR: begin
                state_d = ST_ERR;
            end
`endif
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            cnt_q         <= 3'd0;
            ridx_q        <= 2'd0;
            load_en_q     <= 1'b0;
            load_sel_ab_q <= 1'b0;
            load_index_q  <= 2'd0;
            load_data_q   <= 8'd0;
            res_byte_q    <= 8'd0;
`ifdef TPU_SEQ_TIMEOUT_EN
            wcnt_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ridx_q        <= ridx_d;
            load_en_q     <= load_en_d;
            load_sel_ab_q <= load_sel_ab_d;
            load_index_q  <= load_index_d;
            load_data_q   <= load_data_d;
            res_byte_q    <= res_byte_d;
`ifdef TPU_SEQ_TIMEOUT_EN
            wcnt_q        <= wcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Directed bench for tpu_host_sequencer: per-cycle vector table plus
// hand-written reset, early-done and watchdog sequences.
module tb_tpu_host_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       load_en;
    logic       load_sel_ab;
    logic [1:0] load_index;
    logic [7:0] load_data;
    logic       done;
    logic       output_en;
    logic [1:0] output_sel;
    logic [7:0] out_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_byte;
    logic       busy;
    logic       err;

    int tests = 0;
    int fails = 0;

    tpu_host_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .load_en    (load_en),
        .load_sel_ab(load_sel_ab),
        .load_index (load_index),
        .load_data  (load_data),
        .done       (done),
        .output_en  (output_en),
        .output_sel (output_sel),
        .out_data   (out_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_byte   (res_byte),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Controller model: result element k reads back as 0x10 + k
    assign out_data = 8'h10 + {6'd0, output_sel};

    typedef struct {
        logic        in_valid;
        logic [7:0]  in_byte;
        logic        done;
        logic        res_ready;
        logic [26:0] exp;
    } vec_t;

    localparam int NV = 31;
    vec_t tbl [NV];

    function automatic logic [26:0] obs();
        return {load_en, load_sel_ab, load_index, load_data, in_ready, busy,
                output_en, output_sel, res_valid, res_byte, err};
    endfunction

    function automatic logic [26:0] ex(int le, int sel, int idx, int dat, int ir,
                                       int bz, int oe, int os, int rv, int rb, int er);
        return {1'(le), 1'(sel), 2'(idx), 8'(dat), 1'(ir), 1'(bz), 1'(oe),
                2'(os), 1'(rv), 8'(rb), 1'(er)};
    endfunction

    function automatic vec_t mk(int v, int b, int d, int rr, int le, int sel, int idx,
                                int dat, int ir, int bz, int oe, int os, int rv, int rb);
        vec_t t;
        t.in_valid  = 1'(v);
        t.in_byte   = 8'(b);
        t.done      = 1'(d);
        t.res_ready = 1'(rr);
        t.exp       = ex(le, sel, idx, dat, ir, bz, oe, os, rv, rb, 0);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream 8 bytes back-to-back, checking each strobe the cycle after acceptance
    task automatic load8(input logic [7:0] base, input logic done_last);
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kk;
            logic [7:0] dat;
            kk       = 3'(k);
            dat      = base + 8'(k);
            in_valid = 1'b1;
            in_byte  = dat;
            done     = (k == 7) ? done_last : 1'b0;
            @(negedge clk);
            chk($sformatf("strobe%0d", k), 32'({load_en, load_sel_ab, load_index, load_data}),
                32'({1'b1, kk[2], kk[1:0], dat}));
        end
        in_valid = 1'b0;
        chk("wait_entry", 32'({in_ready, busy}), 32'(2'b01));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        done      = 1'b0;
        res_ready = 1'b0;

        //           v  byte d  rr le s idx dat ir bz oe os rv rb
        tbl[0]  = mk(1, 'h01, 0, 0, 0, 0, 0, 'h00, 1, 0, 0, 0, 0, 'h00);
        tbl[1]  = mk(1, 'h02, 0, 0, 1, 0, 0, 'h01, 1, 1, 0, 0, 0, 'h00);
        tbl[2]  = mk(1, 'h03, 0, 0, 1, 0, 1, 'h02, 1, 1, 0, 0, 0, 'h00);
        tbl[3]  = mk(1, 'h04, 0, 0, 1, 0, 2, 'h03, 1, 1, 0, 0, 0, 'h00);
        tbl[4]  = mk(0, 'h00, 1, 0, 1, 0, 3, 'h04, 1, 1, 0, 0, 0, 'h00);
        tbl[5]  = mk(0, 'h00, 1, 0, 0, 0, 3, 'h04, 1, 1, 0, 0, 0, 'h00);
        tbl[6]  = mk(0, 'h00, 0, 0, 0, 0, 3, 'h04, 1, 1, 0, 0, 0, 'h00);
        tbl[7]  = mk(1, 'h05, 0, 0, 0, 0, 3, 'h04, 1, 1, 0, 0, 0, 'h00);
        tbl[8]  = mk(1, 'h06, 0, 0, 1, 1, 0, 'h05, 1, 1, 0, 0, 0, 'h00);
        tbl[9]  = mk(1, 'h07, 0, 0, 1, 1, 1, 'h06, 1, 1, 0, 0, 0, 'h00);
        tbl[10] = mk(1, 'h08, 0, 0, 1, 1, 2, 'h07, 1, 1, 0, 0, 0, 'h00);
        tbl[11] = mk(1, 'h09, 0, 0, 1, 1, 3, 'h08, 0, 1, 0, 0, 0, 'h00);
        tbl[12] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 0, 0, 0, 'h00);
        tbl[13] = mk(0, 'h00, 1, 0, 0, 1, 3, 'h08, 0, 1, 0, 0, 0, 'h00);
        tbl[14] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 1, 0, 0, 'h00);
        tbl[15] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 0, 0, 1, 'h10);
        tbl[16] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 0, 0, 1, 'h10);
        tbl[17] = mk(0, 'h00, 0, 1, 0, 1, 3, 'h08, 0, 1, 0, 0, 1, 'h10);
        tbl[18] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 1, 1, 0, 'h10);
        tbl[19] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 0, 1, 1, 'h11);
        tbl[20] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 0, 1, 1, 'h11);
        tbl[21] = mk(0, 'h00, 0, 1, 0, 1, 3, 'h08, 0, 1, 0, 1, 1, 'h11);
        tbl[22] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 1, 2, 0, 'h11);
        tbl[23] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 0, 2, 1, 'h12);
        tbl[24] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 0, 2, 1, 'h12);
        tbl[25] = mk(0, 'h00, 0, 1, 0, 1, 3, 'h08, 0, 1, 0, 2, 1, 'h12);
        tbl[26] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 1, 3, 0, 'h12);
        tbl[27] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 0, 3, 1, 'h13);
        tbl[28] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 0, 1, 0, 3, 1, 'h13);
        tbl[29] = mk(0, 'h00, 0, 1, 0, 1, 3, 'h08, 0, 1, 0, 3, 1, 'h13);
        tbl[30] = mk(0, 'h00, 0, 0, 0, 1, 3, 'h08, 1, 0, 0, 0, 0, 'h13);

        // Reset state: only in_ready high
        repeat (2) @(negedge clk);
        chk("reset", 32'(obs()), 32'(ex(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
        rst = 1'b0;

        // Load with stall and early done, then drain with res_ready backpressure
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
            in_valid  = tbl[i].in_valid;
            in_byte   = tbl[i].in_byte;
            done      = tbl[i].done;
            res_ready = tbl[i].res_ready;
        end

        // Reset while presenting result 2
        load8(8'h21, 1'b0);
        done = 1'b1;
        @(negedge clk);
        chk("sel0", 32'({output_en, output_sel}), 32'({1'b1, 2'd0}));
        done      = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("pres0", 32'({res_valid, res_byte}), 32'({1'b1, 8'h10}));
        @(negedge clk);
        @(negedge clk);
        chk("pres1", 32'({res_valid, res_byte}), 32'({1'b1, 8'h11}));
        @(negedge clk);
        res_ready = 1'b0;
        @(negedge clk);
        chk("pres2", 32'({res_valid, res_byte, output_sel}), 32'({1'b1, 8'h12, 2'd2}));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset", 32'(obs()), 32'(ex(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
        rst = 1'b0;

        // Fresh load with done already high on WAIT entry, then full drain
        load8(8'h31, 1'b1);
        @(negedge clk);
        chk("done_on_entry", 32'({output_en, output_sel}), 32'({1'b1, 2'd0}));
        done      = 1'b0;
        res_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if (r > 0) begin
                @(negedge clk);
                chk($sformatf("drain_sel%0d", r), 32'({output_en, output_sel}),
                    32'({1'b1, 2'(r)}));
            end
            @(negedge clk);
            chk($sformatf("drain_res%0d", r), 32'({res_valid, res_byte}),
                32'({1'b1, 8'h10 + 8'(r)}));
        end
        @(negedge clk);
        chk("back_to_load", 32'({in_ready, busy, res_valid, output_en}), 32'(4'b1000));
        res_ready = 1'b0;

        // Watchdog behaviour
        load8(8'h41, 1'b0);
`ifdef TPU_SEQ_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk("wait16_no_err", 32'({err, in_ready}), 32'(2'b00));
        @(negedge clk);
        chk("err_set", 32'({err, busy, in_ready, res_valid}), 32'(4'b1100));
        done = 1'b1;
        repeat (20) @(negedge clk);
        chk("err_sticky", 32'({err, busy, in_ready, res_valid, output_en}), 32'(5'b11000));
        done = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared", 32'({err, in_ready, busy}), 32'(3'b010));
`else
        repeat (1000) @(negedge clk);
        chk("wait_forever", 32'({err, busy, in_ready, output_en, res_valid}), 32'(5'b01000));
        done = 1'b1;
        @(negedge clk);
        chk("late_done", 32'({output_en, err}), 32'(2'b10));
        done = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tpu_host_sequencer.md
# tpu_host_sequencer

Host-side sequencer in front of the TPU matrix controller. It accepts a byte stream over a valid/ready handshake, issues one load strobe per byte to fill the 4-entry A and B operand vectors, waits for the array's `done`, then reads the 4 result bytes through the controller's output select port and returns them over a second valid/ready stream. Each run is load 8 → compute → drain 4 → repeat.

## Interface
- `TIMEOUT_CYCLES`, default 64: watchdog limit in WAIT; only used with `TPU_SEQ_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  host byte valid.
- `in_ready`  out  1  sequencer can accept a byte.
- `in_byte`  in  8  host byte.
- `load_en`  out  1  one-cycle load strobe to the controller.
- `load_sel_ab`  out  1  0 = A vector, 1 = B vector.
- `load_index`  out  2  element index.
- `load_data`  out  8  element value.
- `done`  in  1  compute complete (level or pulse).
- `output_en`  out  1  result read enable to the controller.
- `output_sel`  out  2  result element index.
- `out_data`  in  8  result byte from the controller.
- `res_valid`  out  1  result byte valid.
- `res_ready`  in  1  host accepts the result byte.
- `res_byte`  out  8  result byte.
- `busy`  out  1  high in every state except LOAD with `cnt`=0.
- `err`  out  1  watchdog fired (sticky until `rst`); always 0 without the macro.

## Operation
- States: LOAD, WAIT, SEL, PRES, and ERR (ERR exists only with the macro).
- Counters:
  - 3-bit `cnt`: bytes loaded, 0..7.
  - 2-bit `ridx`: result index, 0..3.
- Reset:
  - State goes to LOAD; `cnt` and `ridx` go to 0.
  - All outputs are 0 except `in_ready`, which is 1.
- LOAD:
  - `in_ready`=1.
  - On `in_valid&&in_ready`, the next cycle drives `load_en`=1 with `load_sel_ab`=`cnt[2]`, `load_index`=`cnt[1:0]`, `load_data`=`in_byte`. `cnt` increments.
  - Byte order: A0..A3, then B0..B3.
  - When the 8th byte is accepted (`cnt`=7), move to WAIT. `cnt` wraps to 0.
- WAIT:
  - `in_ready`=0.
  - On the first cycle with `done`=1, move to SEL with `ridx`=0.
  - `done` is ignored in all other states.
- SEL:
  - `output_en`=1, `output_sel`=`ridx`.
  - Next cycle: `res_byte` ← `out_data`, then move to PRES.
- PRES:
  - `res_valid`=1. `res_byte` and `output_sel` are held stable until `res_ready`.
  - On `res_valid&&res_ready`:
    - If `ridx`=3: move to LOAD.
    - Otherwise: increment `ridx` and move to SEL.
- `load_en`, `load_sel_ab`, `load_index`, `load_data` and `res_byte` are registered. `in_ready`, `output_en`, `output_sel` and `res_valid` decode from state.
- `load_sel_ab`, `load_index` and `load_data` hold their last value when `load_en`=0.

## Timing
- Byte accepted at edge N → `load_en` high during cycle N+1, for exactly one cycle.
- Back-to-back bytes are accepted at 1 byte/cycle. 8 bytes take 8 cycles; the last strobe lands in the first WAIT cycle.
- `done` seen at edge M → SEL during cycle M+1, PRES (`res_valid`) during cycle M+2.
- Each result takes 2 cycles minimum (SEL + PRES with `res_ready`=1). A full drain takes ≥8 cycles.
- `in_valid` deasserted mid-load: `cnt` holds and there is no strobe. There is no partial-load timeout.
- `res_ready` low: PRES holds indefinitely; `res_byte` does not change.
- `rst` asserted mid-operation: the next edge returns to LOAD. Any pending `load_en` is cleared; `res_valid` is cleared.
- `done` already high when WAIT is entered: transition on the first WAIT edge.

## Configuration
- `TPU_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `done` has not been seen after `TIMEOUT_CYCLES` WAIT cycles, move to ERR.
  - ERR: `err`=1, `busy`=1, `in_ready`=0, `res_valid`=0. Only `rst` exits ERR.
- `TPU_SEQ_TIMEOUT_EN` undefined:
  - No counter and no ERR state; WAIT waits forever.
  - `err` is tied to 0 and `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset, then stream bytes 1..8 back-to-back → `load_en` pulses on 8 consecutive cycles with (sel,idx,data) = (0,0,1)…(0,3,4),(1,0,5)…(1,3,8); `busy`=1, `in_ready`=0 afterwards.
- Stall the host: `in_valid` low for 3 cycles between bytes 4 and 5 → no strobe during the gap; B0=5 still loads at index 0.
- Pulse `done`; the controller model returns `out_data`=0x10+`output_sel` → `res_byte` 0x10,0x11,0x12,0x13 in order, each held while `res_ready`=0 for 2 cycles.
- Assert `done` during LOAD, then complete the load → the early `done` is ignored; the WAIT→SEL transition happens only on a later `done`.
- Assert `rst` during PRES with `ridx`=2 → next cycle: LOAD, `res_valid`=0, `in_ready`=1, `load_en`=0; a fresh 8-byte load behaves as from reset.
- With `TPU_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: never assert `done` → `err`=1 after 16 WAIT cycles and stays 1 until `rst`. Without the macro: still in WAIT after 1000 cycles, `err`=0.
